// File: rtl/ham_scrub_ctrl.sv
// Shares one Hamming(14,10) decoder/encoder between host reads and a background scrubber.
// Optional HAM_HOST_WB_EN: host reads that hit an error also write the corrected codeword back.
module ham_scrub_ctrl #(
  parameter int AW             = 4,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scrub_en,
  input  logic             host_req,
  input  logic [AW-1:0]    host_addr,
  output logic             host_gnt,
  output logic             host_valid,
  output logic [9:0]       host_rdata,
  output logic             host_err,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_re,
  input  logic [13:0]      mem_rdata,
  output logic             mem_we,
  output logic [13:0]      mem_wdata,
  output logic [13:0]      dec_data,
  output logic             dec_en,
  input  logic [9:0]       dec_out,
  input  logic             dec_err,
  output logic [9:0]       enc_data,
  input  logic [13:0]      enc_code,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr,
  output logic             pass_done
);

  localparam int TW = $clog2(SCRUB_INTERVAL);

`ifdef HAM_HOST_WB_EN
  typedef enum logic [2:0] {IDLE, S_RD, S_DEC, S_WB, H_RD, H_DEC, H_WB} state_t;
`else
  typedef enum logic [2:0] {IDLE, S_RD, S_DEC, S_WB, H_RD, H_DEC} state_t;
`endif

  state_t          state, state_nx;
  logic [TW-1:0]   timer;
  logic            scrub_pend;
  logic [AW-1:0]   scrub_addr;
  logic            last_host;
  logic [9:0]      corr_r;
  logic            advance;
  logic            host_ok;

  // In the host_valid cycle the finished request is still high; it must not be re-issued.
  assign host_ok = host_req && !host_valid;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nx  = state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dec_data  = '0;
    dec_en    = 1'b0;
    enc_data  = '0;
    host_gnt  = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        if (host_ok && scrub_pend) state_nx = last_host ? S_RD : H_RD;
        else if (host_ok)          state_nx = H_RD;
        else if (scrub_pend)       state_nx = S_RD;
      end
      S_RD: begin
        mem_re   = 1'b1;
        mem_addr = scrub_addr;
        state_nx = S_DEC;
      end
      S_DEC: begin
        dec_data = mem_rdata;
        dec_en   = 1'b1;
        if (dec_err) begin
          state_nx = S_WB;
        end else begin
          advance  = 1'b1;
          state_nx = IDLE;
        end
      end
      S_WB: begin
        enc_data  = corr_r;
        mem_we    = 1'b1;
        mem_wdata = enc_code;
        mem_addr  = scrub_addr;
        advance   = 1'b1;
        state_nx  = IDLE;
      end
      H_RD: begin
        mem_re   = 1'b1;
        mem_addr = host_addr;
        host_gnt = 1'b1;
        state_nx = H_DEC;
      end
      H_DEC: begin
        dec_data = mem_rdata;
        dec_en   = 1'b1;
`ifdef HAM_HOST_WB_EN
        state_nx = dec_err ? H_WB : IDLE;
`else
        state_nx = IDLE;
`endif
      end
`ifdef HAM_HOST_WB_EN
      H_WB: begin
        enc_data  = corr_r;
        mem_we    = 1'b1;
        mem_wdata = enc_code;
        mem_addr  = host_addr;
        state_nx  = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  assign pass_done = advance && (scrub_addr == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      scrub_pend <= 1'b0;
      scrub_addr <= '0;
      last_host  <= 1'b0;
      corr_r     <= '0;
      host_valid <= 1'b0;
      host_rdata <= '0;
      host_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;

      if (!scrub_en) begin
        timer <= '0;
      end else if (!scrub_pend) begin
        if (timer == TW'(SCRUB_INTERVAL - 1)) begin
          timer      <= '0;
          scrub_pend <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end

      // Advance only happens while scrub_pend is set, so it never races the timer's set.
      if (advance) begin
        scrub_pend <= 1'b0;
        scrub_addr <= scrub_addr + 1'b1;
      end

      if (state == H_DEC || state_nx == IDLE && state != S_DEC && state != S_WB && state != IDLE)
        last_host <= 1'b1;
      if (state == S_DEC || state == S_WB)
        last_host <= 1'b0;

      if (dec_en) corr_r <= dec_out;

      host_valid <= (state == H_DEC);
      if (state == H_DEC) begin
        host_rdata <= dec_out;
        host_err   <= dec_err;
      end

      if (err_clr)                             err_cnt <= '0;
      else if (dec_en && dec_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ham_scrub_ctrl.sv
// Self-checking bench for ham_scrub_ctrl: behavioural Hamming(14,10) codec and memory, table and random host reads.
module tb_ham_scrub_ctrl;

  logic        clk;
  logic        rst;
  logic        scrub_en;
  logic        host_req;
  logic [3:0]  host_addr;
  logic        host_gnt;
  logic        host_valid;
  logic [9:0]  host_rdata;
  logic        host_err;
  logic [3:0]  mem_addr;
  logic        mem_re;
  logic [13:0] mem_rdata;
  logic        mem_we;
  logic [13:0] mem_wdata;
  logic [13:0] dec_data;
  logic        dec_en;
  logic [9:0]  dec_out;
  logic        dec_err;
  logic [9:0]  enc_data;
  logic [13:0] enc_code;
  logic [7:0]  err_cnt;
  logic        err_clr;
  logic        pass_done;

  ham_scrub_ctrl #(.AW(4), .SCRUB_INTERVAL(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_valid(host_valid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .dec_data(dec_data), .dec_en(dec_en), .dec_out(dec_out), .dec_err(dec_err),
    .enc_data(enc_data), .enc_code(enc_code),
    .err_cnt(err_cnt), .err_clr(err_clr), .pass_done(pass_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Codeword bit p-1 holds Hamming position p; parity at positions 1,2,4,8.
  function automatic logic [13:0] ham_enc(input logic [9:0] d);
    logic [13:0] cw;
    logic par;
    int k;
    cw = '0;
    k = 0;
    for (int p = 1; p <= 14; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p <= 14; p++)
        if ((p & (1 << b)) != 0) par ^= cw[p-1];
      cw[(1 << b) - 1] = par;
    end
    return cw;
  endfunction

  function automatic logic [10:0] ham_dec(input logic [13:0] cw_in);
    logic [13:0] cw;
    logic [3:0]  syn;
    logic [9:0]  d;
    int k;
    cw  = cw_in;
    syn = '0;
    for (int p = 1; p <= 14; p++)
      if (cw[p-1]) syn ^= 4'(p);
    if (syn != 4'd0 && syn <= 4'd14) cw[int'(syn) - 1] = ~cw[int'(syn) - 1];
    d = '0;
    k = 0;
    for (int p = 1; p <= 14; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[p-1];
        k++;
      end
    end
    return {syn != 4'd0, d};
  endfunction

  assign {dec_err, dec_out} = ham_dec(dec_data);
  assign enc_code = ham_enc(enc_data);

  // Behavioural single-port memory with a bench-side preload port.
  logic [13:0] mem [16];
  logic        tb_we;
  logic [3:0]  tb_waddr;
  logic [13:0] tb_wdata;
  logic [9:0]  data_m [16];

  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (tb_we)       mem[tb_waddr] <= tb_wdata;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Bus monitor, sampled on the falling edge.
  int         n_reads, n_scrub, n_writes, n_pass, n_overlap;
  logic [7:0] kidx;
  logic [5:0] sidx;
  bit         kind_log [256];
  logic [3:0] scrub_log [64];
  logic [3:0] last_wa;
  logic [13:0] last_wd;

  initial begin
    n_reads = 0; n_scrub = 0; n_writes = 0; n_pass = 0; n_overlap = 0;
    kidx = '0; sidx = '0; last_wa = '0; last_wd = '0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_re) begin
        n_reads         <= n_reads + 1;
        kind_log[kidx]  <= host_gnt;
        kidx            <= kidx + 8'd1;
        if (!host_gnt) begin
          n_scrub         <= n_scrub + 1;
          scrub_log[sidx] <= mem_addr;
          sidx            <= sidx + 6'd1;
        end
      end
      if (mem_we) begin
        n_writes <= n_writes + 1;
        last_wa  <= mem_addr;
        last_wd  <= mem_wdata;
      end
      if (pass_done)         n_pass    <= n_pass + 1;
      if (mem_re && mem_we)  n_overlap <= n_overlap + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic poke(input logic [3:0] a, input logic [13:0] w);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = w;
    tick();
    tb_we = 1'b0;
  endtask

  // Issues one host read from an idle controller and checks latency, data and write-back.
  task automatic host_read(input logic [3:0] a, input logic [9:0] exp_d, input logic exp_err,
                           input bit clr_in_dec);
    int k;
    bit seen;
    host_req = 1'b1; host_addr = a;
    k = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      tick(); k++; seen = host_gnt;
    end
    if (!seen) begin
      check("host_gnt_timeout", 32'd0, 32'd1);
      host_req = 1'b0;
      tick();
      return;
    end
    check("host_gnt_latency", 32'(k), 32'd1);
    k = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      tick(); k++;
      err_clr = clr_in_dec && (k == 1);
      seen = host_valid;
    end
    err_clr = 1'b0;
    if (!seen) begin
      check("host_valid_timeout", 32'd0, 32'd1);
    end else begin
      check("host_valid_latency", 32'(k), 32'd2);
      check("host_rdata", 32'(host_rdata), 32'(exp_d));
      check("host_err", 32'(host_err), 32'(exp_err));
`ifdef HAM_HOST_WB_EN
      check("host_wb_we", 32'(mem_we), 32'(exp_err));
      if (exp_err) begin
        check("host_wb_addr", 32'(mem_addr), 32'(a));
        check("host_wb_data", 32'(mem_wdata), 32'(ham_enc(exp_d)));
      end
`else
      check("host_no_wb", 32'(mem_we), 32'd0);
`endif
    end
    host_req = 1'b0;
    tick();
    check("host_valid_pulse", 32'(host_valid), 32'd0);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [9:0] data;
    int         flip;
    logic [9:0] exp_d;
    logic       exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int k, exp_cnt, model_cnt;
    int base_s, base_w, base_p;
    logic [7:0] kb;
    logic [5:0] sb, j;
    logic [3:0] ra;
    logic [9:0] rd;
    logic [13:0] cw;
    bit corrupt;

    vecs[0] = '{4'd9,  10'h2A5, -1, 10'h2A5, 1'b0};
    vecs[1] = '{4'd3,  10'h155,  0, 10'h155, 1'b1};
    vecs[2] = '{4'd7,  10'h3FF, 13, 10'h3FF, 1'b1};
    vecs[3] = '{4'd0,  10'h000,  2, 10'h000, 1'b1};
    vecs[4] = '{4'd15, 10'h0F0, -1, 10'h0F0, 1'b0};
    vecs[5] = '{4'd12, 10'h1C3,  8, 10'h1C3, 1'b1};

    rst = 1'b1; scrub_en = 1'b0; host_req = 1'b0; host_addr = '0; err_clr = 1'b0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_mem_re",     32'(mem_re), 32'd0);
    check("rst_mem_we",     32'(mem_we), 32'd0);
    check("rst_host_gnt",   32'(host_gnt), 32'd0);
    check("rst_host_valid", 32'(host_valid), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    check("rst_dec_en",     32'(dec_en), 32'd0);
    check("rst_dec_data",   32'(dec_data), 32'd0);
    check("rst_mem_addr",   32'(mem_addr), 32'd0);
    check("rst_err_cnt",    32'(err_cnt), 32'd0);
    check("rst_pass_done",  32'(pass_done), 32'd0);

    for (int i = 0; i < 16; i++) begin
      data_m[i] = 10'($urandom);
      poke(4'(i), ham_enc(data_m[i]));
    end

    // Table-driven host reads
    exp_cnt = 0;
    foreach (vecs[i]) begin
      cw = ham_enc(vecs[i].data);
      if (vecs[i].flip >= 0) cw[vecs[i].flip] = ~cw[vecs[i].flip];
      poke(vecs[i].addr, cw);
      host_read(vecs[i].addr, vecs[i].exp_d, vecs[i].exp_err, 1'b0);
      if (vecs[i].exp_err) exp_cnt++;
      check("table_err_cnt", 32'(err_cnt), 32'(exp_cnt));
    end

    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 16; i++) poke(4'(i), ham_enc(data_m[i]));

    // Full clean scrub pass
    base_s = n_scrub; base_w = n_writes; base_p = n_pass; sb = sidx;
    scrub_en = 1'b1;
    k = 0;
    while (n_scrub - base_s < 16 && k < 2000) begin tick(); k++; end
    scrub_en = 1'b0;
    check("pass_timeout", 32'(n_scrub - base_s), 32'd16);
    repeat (5) tick();
    for (int i = 0; i < 16; i++) begin
      j = sb + 6'(i);
      check("scrub_order", 32'(scrub_log[j]), 32'(i));
    end
    check("pass_done_once", 32'(n_pass - base_p), 32'd1);
    check("pass_no_write", 32'(n_writes - base_w), 32'd0);
    check("pass_err_cnt", 32'(err_cnt), 32'd0);

    // Scrub write-back of a corrupted word 5
    poke(4'd5, ham_enc(data_m[5]) ^ 14'h0040);
    base_s = n_scrub; base_w = n_writes;
    scrub_en = 1'b1;
    k = 0;
    while (n_writes == base_w && k < 2000) begin tick(); k++; end
    check("scrub_wb_count", 32'(n_writes - base_w), 32'd1);
    check("scrub_wb_reads", 32'(n_scrub - base_s), 32'd6);
    check("scrub_wb_addr", 32'(last_wa), 32'd5);
    check("scrub_wb_data", 32'(last_wd), 32'(ham_enc(data_m[5])));
    k = 0;
    while (n_scrub - base_s < 22 && k < 2000) begin tick(); k++; end
    scrub_en = 1'b0;
    repeat (5) tick();
    check("rescrub_reads", 32'(n_scrub - base_s), 32'd22);
    check("rescrub_no_write", 32'(n_writes - base_w), 32'd1);
    check("scrub_err_cnt", 32'(err_cnt), 32'd1);
    check("mem5_fixed", 32'(mem[5]), 32'(ham_enc(data_m[5])));

    // Host and scrub pending together after a scrub: host first, then scrub, then the held host
    kb = kidx; sb = sidx;
    scrub_en = 1'b1;
    repeat (4) tick();
    host_req = 1'b1; host_addr = 4'd2; scrub_en = 1'b0;
    k = 0;
    while (!host_valid && k < 20) begin tick(); k++; end
    check("arb_first_valid", 32'(host_valid), 32'd1);
    check("arb_first_rdata", 32'(host_rdata), 32'(data_m[2]));
    tick();
    k = 0;
    while (!host_valid && k < 30) begin tick(); k++; end
    check("arb_second_valid", 32'(host_valid), 32'd1);
    check("arb_second_rdata", 32'(host_rdata), 32'(data_m[2]));
    host_req = 1'b0;
    repeat (3) tick();
    check("arb_read_count", 32'(kidx - kb), 32'd3);
    check("arb_order0_host", 32'(kind_log[kb]), 32'd1);
    check("arb_order1_scrub", 32'(kind_log[kb + 8'd1]), 32'd0);
    check("arb_order2_host", 32'(kind_log[kb + 8'd2]), 32'd1);
    check("arb_scrub_addr", 32'(scrub_log[sb]), 32'd6);

    // Random host reads against the codec/memory model, driving err_cnt into saturation
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    model_cnt = 0;
    for (int n = 0; n < 500; n++) begin
      ra = 4'($urandom_range(0, 15));
      rd = 10'($urandom);
      corrupt = ($urandom_range(0, 3) != 0);
      data_m[ra] = rd;
      cw = ham_enc(rd);
      if (corrupt) cw = cw ^ (14'd1 << $urandom_range(0, 13));
      poke(ra, cw);
      host_read(ra, rd, corrupt, 1'b0);
      if (corrupt && model_cnt < 255) model_cnt++;
      check("rand_err_cnt", 32'(err_cnt), 32'(model_cnt));
    end
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    poke(4'd4, ham_enc(data_m[4]) ^ 14'h0100);
    host_read(4'd4, data_m[4], 1'b1, 1'b1);
    check("err_clr_priority", 32'(err_cnt), 32'd0);

    // Reset during a scrub decode that flags an error
    rst = 1'b1;
    tick();
    poke(4'd0, ham_enc(data_m[0]) ^ 14'h0008);
    rst = 1'b0;
    base_w = n_writes;
    scrub_en = 1'b1;
    k = 0;
    while (!mem_re && k < 20) begin tick(); k++; end
    check("rst_scrub_read", 32'(mem_re), 32'd1);
    tick();
    check("rst_sdec_en", 32'(dec_en), 32'd1);
    check("rst_sdec_err", 32'(dec_err), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_abort_we", 32'(mem_we), 32'd0);
    check("rst_abort_dec", 32'(dec_en), 32'd0);
    rst = 1'b0; scrub_en = 1'b0;
    repeat (6) tick();
    check("rst_abort_no_write", 32'(n_writes - base_w), 32'd0);
    check("rst_abort_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_abort_valid", 32'(host_valid), 32'd0);

    check("re_we_overlap", 32'(n_overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ham_scrub_ctrl.md
Name: ham_scrub_ctrl

Overview:
- Sequencer for a Hamming (14,10) protected word memory. Shares one external ham_dec_14_10 decoder and one external (14,10) encoder between host read requests and a background scrubber.
- The scrubber periodically reads each word, decodes it, and writes the re-encoded corrected word back when the decoder flags an error.
- Sits between the host, the single-port ECC memory and the decode/encode datapath. Counts corrected errors for status.

Parameters:
- AW, 4, memory address width; DEPTH = 2**AW words.
- SCRUB_INTERVAL, 256, idle cycles between scrub reads; legal range ≥2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- scrub_en  in  1  enables the interval timer and scrubbing.
- host_req  in  1  read request, level; held until host_valid.
- host_addr  in  AW  read address; stable while host_req=1.
- host_gnt  out  1  1-cycle pulse when the host read is issued to memory.
- host_valid  out  1  1-cycle pulse, read data ready.
- host_rdata  out  10  corrected data word.
- host_err  out  1  decoder flagged an error on this read; qualified by host_valid.
- mem_addr  out  AW  memory address.
- mem_re  out  1  memory read strobe; mem_rdata is valid the next cycle.
- mem_rdata  in  14  memory read data.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  14  write-back codeword.
- dec_data  out  14  codeword to decoder data_i.
- dec_en  out  1  decoder enable.
- dec_out  in  10  decoder data_o.
- dec_err  in  1  decoder err.
- enc_data  out  10  data to encoder input.
- enc_code  in  14  encoder codeword output (combinational).
- err_cnt  out  CNT_W  saturating count of corrected errors (scrub and host).
- err_clr  in  1  synchronous clear of err_cnt.
- pass_done  out  1  1-cycle pulse when the scrubber finishes address DEPTH-1.

Behaviour:
- States: IDLE, S_RD, S_DEC, S_WB, H_RD, H_DEC, H_WB (H_WB exists only with the macro).
- Reset values:
  - state = IDLE, all counters and addresses = 0, scrub_pend = 0, last_host = 0.
  - All outputs = 0.
  - A reset mid-transaction aborts it: no mem_we, no host_valid.
- Timer:
  - Counts while scrub_en=1 and scrub_pend=0.
  - At SCRUB_INTERVAL-1 it sets scrub_pend and reloads to 0.
  - scrub_en=0 clears the timer but keeps scrub_pend.
- IDLE arbitration:
  - host_req only → H_RD.
  - scrub_pend only → S_RD.
  - Both asserted: if last_host=1 → S_RD, else → H_RD.
  - last_host is set on leaving H_DEC or H_WB and cleared on leaving S_DEC or S_WB.
- S_RD: mem_re=1, mem_addr=scrub_addr → S_DEC.
- S_DEC:
  - dec_data=mem_rdata, dec_en=1; register dec_out into corr_r.
  - If dec_err=1: → S_WB.
  - Otherwise: clear scrub_pend, advance scrub_addr, → IDLE.
- S_WB:
  - enc_data=corr_r, mem_we=1, mem_wdata=enc_code, mem_addr=scrub_addr.
  - Clear scrub_pend, advance scrub_addr, → IDLE.
- Scrub address advance: wraps from DEPTH-1 to 0 with pass_done=1 in the same cycle.
- H_RD: mem_re=1, mem_addr=host_addr, host_gnt=1 → H_DEC.
- H_DEC:
  - dec_data=mem_rdata, dec_en=1.
  - host_rdata and host_err are registered and host_valid=1 on the next cycle.
  - Host latency: IDLE sample at t, mem_re at t+1, host_valid at t+3.
  - Without the macro: → IDLE.
- dec_en=0 and dec_data=0 outside S_DEC and H_DEC.
- mem_re and mem_we are never asserted in the same cycle.
- err_cnt: +1 on each dec_err=1 in S_DEC or H_DEC; saturates at 2**CNT_W-1. err_clr has priority: an increment in the same cycle is lost and err_cnt=0.
- A host_req deasserted before host_gnt is dropped. A host_req held after host_valid is treated as a new request.

Optional Feature:
- HAM_HOST_WB_EN defined:
  - An error on a host read goes H_DEC → H_WB.
  - H_WB drives enc_data=corrected word, mem_we=1, mem_wdata=enc_code, mem_addr=host_addr, → IDLE.
  - host_valid still pulses at t+3, coincident with H_WB.
- Undefined: no host write-back; host errors are only counted and reported.

Test Plan:
- Reset, scrub_en=1, SCRUB_INTERVAL=4, clean memory → a read every pass; after 16 reads pass_done pulses once with scrub_addr back to 0; no mem_we; err_cnt=0.
- Word 5 holds a codeword with bit 6 flipped → scrub of address 5 gives S_WB with mem_wdata = correct codeword, mem_addr=5, err_cnt=1; a re-scrub of 5 produces no write.
- host_req addr 9 from IDLE at cycle t, clean data 10'h2A5 → host_gnt at t+1, host_valid at t+3, host_rdata=10'h2A5, host_err=0.
- host_req and scrub_pend asserted together with last_host=0 → host served first, then the scrub; a back-to-back host_req waits for the scrub (no starvation).
- err_cnt at 255 (CNT_W=8) plus another error → stays 255; err_clr coincident with an error → 0.
- rst asserted in the S_DEC cycle with dec_err=1 → next cycle IDLE, mem_we never asserted. With HAM_HOST_WB_EN, a host read of a corrupted word → mem_we at t+3 with the corrected codeword.
